// File: rtl/word_ser_pkg.sv
// rtl/word_ser_pkg.sv - shared constants, byte-counter encoding and byte selector for the word serializer
package word_ser_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;

  // Byte counter doubles as the FSM state: CNT_SLOT may accept, the rest emit the held word.
  typedef enum logic [1:0] {
    CNT_SLOT = 2'd0,
    CNT_B1   = 2'd1,
    CNT_B2   = 2'd2,
    CNT_B3   = 2'd3
  } cnt_t;

  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        idx);
    return word[BYTE_W*(BYTES_PER_WORD-1-int'(idx)) +: BYTE_W];
  endfunction

endpackage

// File: rtl/word32_serial_arbiter_if.sv
// rtl/word32_serial_arbiter_if.sv - lane request bus and serialized byte link
interface word32_serial_arbiter_if
  import word_ser_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LANE_W  = 2
);

  logic [NUM_REQ-1:0]        lane_en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      valid_out_c;
  logic [BYTE_W-1:0]         data_out_c;
  logic [LANE_W-1:0]         lane_out_c;
  logic                      sow_out_c;

  modport master (
    output lane_en, req_valid, req_data,
    input  req_ready, valid_out_c, data_out_c, lane_out_c, sow_out_c
  );

  modport slave (
    input  lane_en, req_valid, req_data,
    output req_ready, valid_out_c, data_out_c, lane_out_c, sow_out_c
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requesting lane after the last served one
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LANE_W  = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LANE_W-1:0]  last,
  output logic [NUM_REQ-1:0] grant,
  output logic [LANE_W-1:0]  idx,
  output logic               any
);

  int   lane_i;
  logic found;

  assign any = |req;

  // Scanning from last+1 and wrapping makes the last-served lane the lowest priority.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    lane_i = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      lane_i = (int'(last) + off) % NUM_REQ;
      if (!found && req[lane_i]) begin
        found         = 1'b1;
        grant[lane_i] = 1'b1;
        idx           = LANE_W'(lane_i);
      end
    end
  end

endmodule

// File: rtl/word32_serial_arbiter.sv
// rtl/word32_serial_arbiter.sv - shares one 32b->8b MSB-first serializer between NUM_REQ lanes
module word32_serial_arbiter
  import word_ser_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LANE_W  = 2
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  word32_serial_arbiter_if.slave   bus
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [LANE_W-1:0]  g_idx;
  logic               any;
  logic [WORD_W-1:0]  word_g;

  cnt_t               cnt,     cnt_n;
  logic [WORD_W-1:0]  hold,    hold_n;
  logic [LANE_W-1:0]  last,    last_n;
  logic [LANE_W-1:0]  lane_q,  lane_n;
  logic [BYTE_W-1:0]  data_q,  data_n;
  logic               valid_q, valid_n;
  logic               sow_q,   sow_n;

  assign eligible = bus.req_valid & bus.lane_en;
  assign word_g   = bus.req_data[int'(g_idx)*WORD_W +: WORD_W];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LANE_W  (LANE_W)
  ) u_arb (
    .req   (eligible),
    .last  (last),
    .grant (grant),
    .idx   (g_idx),
    .any   (any)
  );

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      cnt     <= CNT_SLOT;
      hold    <= '0;
      last    <= LANE_W'(NUM_REQ - 1);
      lane_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sow_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      hold    <= hold_n;
      last    <= last_n;
      lane_q  <= lane_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      sow_q   <= sow_n;
    end
  end

  always_comb begin
    cnt_n   = cnt;
    hold_n  = hold;
    last_n  = last;
    lane_n  = lane_q;
    data_n  = data_q;
    valid_n = valid_q;
    sow_n   = sow_q;
    if (cnt == CNT_SLOT) begin
      if (any) begin
        hold_n  = word_g;
        data_n  = byte_sel(word_g, 2'd0);
        valid_n = 1'b1;
        sow_n   = 1'b1;
        lane_n  = g_idx;
        last_n  = g_idx;
        cnt_n   = CNT_B1;
      end else begin
        valid_n = 1'b0;
        data_n  = '0;
        sow_n   = 1'b0;
      end
    end else begin
      // The held copy is emitted regardless of what the source does after handshake.
      data_n  = byte_sel(hold, cnt);
      valid_n = 1'b1;
      sow_n   = 1'b0;
      cnt_n   = (cnt == CNT_B3) ? CNT_SLOT : cnt_t'(cnt + 2'd1);
    end
  end

  always_comb begin
    bus.req_ready   = (cnt == CNT_SLOT) ? grant : '0;
    bus.valid_out_c = valid_q;
    bus.data_out_c  = data_q;
    bus.lane_out_c  = lane_q;
    bus.sow_out_c   = sow_q;
  end

endmodule

// File: tb/tb_word32_serial_arbiter.sv
// tb/tb_word32_serial_arbiter.sv - randomized and directed checks against a byte-queue reference model
module tb_word32_serial_arbiter;

  localparam int N  = 4;
  localparam int LW = 2;

  typedef struct {
    logic [7:0] d;
    int         lane;
    bit         sow;
  } byte_t;

  logic clk_4f = 1'b0;
  logic reset;

  always #5 clk_4f = ~clk_4f;

  word32_serial_arbiter_if #(.NUM_REQ(N), .LANE_W(LW)) bus ();

  word32_serial_arbiter #(.NUM_REQ(N), .LANE_W(LW)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int         errors = 0;
  int         checks = 0;
  byte_t      q[$];
  int         m_last;
  logic       e_valid;
  logic [7:0] e_data;
  int         e_lane;
  logic       e_sow;
  logic [N-1:0] accepted;
  int         glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] elig);
    for (int off = 1; off <= N; off++) begin
      if (elig[(m_last + off) % N]) return (m_last + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last  = N - 1;
    e_valid = 1'b0;
    e_data  = 8'h00;
    e_lane  = 0;
    e_sow   = 1'b0;
  endtask

  task automatic check_outputs();
    check("valid_out_c", 32'(bus.valid_out_c), 32'(e_valid));
    check("data_out_c",  32'(bus.data_out_c),  32'(e_data));
    check("lane_out_c",  32'(bus.lane_out_c),  32'(e_lane));
    check("sow_out_c",   32'(bus.sow_out_c),   32'(e_sow));
  endtask

  // Called at a negedge with inputs already driven; ends at the following negedge.
  task automatic step();
    logic [N-1:0]  elig;
    logic [N-1:0]  er;
    logic [31:0]   w;
    int            g;
    byte_t         x;
    elig     = bus.req_valid & bus.lane_en;
    g        = (q.size() == 0) ? pick(elig) : -1;
    er       = '0;
    accepted = '0;
    if (g >= 0) er[g] = 1'b1;
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(er));
    if (g >= 0) begin
      w           = bus.req_data[g*32 +: 32];
      m_last      = g;
      accepted[g] = 1'b1;
      glog.push_back(g);
      for (int b = 0; b < 4; b++) q.push_back('{w[31-8*b -: 8], g, (b == 0)});
    end
    if (q.size() > 0) begin
      x       = q.pop_front();
      e_valid = 1'b1;
      e_data  = x.d;
      e_lane  = x.lane;
      e_sow   = x.sow;
    end else begin
      e_valid = 1'b0;
      e_data  = 8'h00;
      e_sow   = 1'b0;
    end
    @(posedge clk_4f);
    @(negedge clk_4f);
    check_outputs();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    model_reset();
    repeat (2) @(negedge clk_4f);
    reset = 1'b0;
    glog.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.lane_en   = '1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    model_reset();
    repeat (3) @(negedge clk_4f);
    check_outputs();
    check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    reset = 1'b0;

    // single word on lane 0
    bus.req_data[31:0] = 32'hA1B2C3D4;
    bus.req_valid      = 4'b0001;
    step();
    check("t1_byte0", 32'(bus.data_out_c), 32'hA1);
    bus.req_valid = '0;
    repeat (3) step();
    check("t1_byte3", 32'(bus.data_out_c), 32'hD4);
    repeat (2) step();

    // all lanes continuously valid
    do_reset();
    for (int i = 0; i < N; i++) bus.req_data[i*32 +: 32] = 32'h0000_0010 * i + i;
    bus.req_valid = '1;
    repeat (20) step();
    for (int k = 0; k < 5; k++) check("rr_order", 32'(glog[k]), 32'(k % N));

    // only lanes 1 and 3 enabled
    do_reset();
    bus.lane_en   = 4'b1010;
    bus.req_valid = '1;
    repeat (16) step();
    for (int k = 0; k < 4; k++) check("en_mask_order", 32'(glog[k]), 32'((k % 2 == 0) ? 1 : 3));
    bus.lane_en = '1;

    // lane 2 withdraws and changes data after handshake
    do_reset();
    bus.req_data[2*32 +: 32] = 32'hDEADBEEF;
    bus.req_valid            = 4'b0100;
    step();
    bus.req_valid            = '0;
    bus.req_data[2*32 +: 32] = 32'h12345678;
    step();
    check("t4_byte1", 32'(bus.data_out_c), 32'hAD);
    repeat (3) step();

    // reset after the second byte
    do_reset();
    bus.req_data[31:0]  = 32'h55AA33CC;
    bus.req_data[63:32] = 32'h01020304;
    bus.req_valid       = 4'b0011;
    repeat (2) step();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    #2;
    reset = 1'b0;
    glog.delete();
    step();
    check("post_reset_grant", 32'(glog[0]), 32'h0);
    repeat (3) step();

    // lane 3 served, then lanes 0 and 3 together
    do_reset();
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    repeat (3) step();
    bus.req_valid = 4'b1001;
    step();
    check("after_lane3_grant", 32'(glog[1]), 32'h0);
    bus.req_valid = '0;
    repeat (7) step();

    // randomized sources and enable mask
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (accepted[i]) begin
          bus.req_valid[i] = ($urandom_range(1) == 1);
          bus.req_data[i*32 +: 32] = $urandom;
        end else if (!bus.req_valid[i] && $urandom_range(9) < 3) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*32 +: 32] = $urandom;
        end
        if ($urandom_range(19) == 0) bus.lane_en[i] = ~bus.lane_en[i];
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
